// File: rtl/axis_pkt_rx_pkg.sv
// Shared types and helpers for the AXI-Stream packet receiver.
package axis_pkt_rx_pkg;

   // Widest TKEEP the helpers handle (DATA_W up to 1024 bits).
   localparam int unsigned KEEP_MAX_W = 128;
   // Widest TID / TDEST a descriptor can carry.
   localparam int unsigned ID_MAX_W   = 16;
   localparam int unsigned DEST_MAX_W = 16;
   // Byte count reported when a packet overflows the 16-bit field.
   localparam logic [15:0] BYTE_SAT   = 16'hFFFF;

   typedef enum logic {
      S_IDLE,
      S_IN_PKT
   } state_t;

   typedef struct packed {
      logic [15:0]           bytes;
      logic [ID_MAX_W-1:0]   id;
      logic [DEST_MAX_W-1:0] dest;
      logic                  err;
   } desc_t;

   // True when keep is a (possibly empty) run of ones starting at bit 0.
   function automatic logic keep_contiguous(input logic [KEEP_MAX_W-1:0] keep);
      return (keep & (keep + KEEP_MAX_W'(1))) == '0;
   endfunction

   // Number of set bits.
   function automatic logic [7:0] popcount(input logic [KEEP_MAX_W-1:0] v);
      logic [7:0] n;
      n = '0;
      for (int unsigned i = 0; i < KEEP_MAX_W; i++) begin
         n = n + 8'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides; no write-through when full.
module axis_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             full, empty, push, pop;

   // Status flags, handshakes and read data (zero while empty)
   always_comb begin
      full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      empty     = (wr_ptr == rd_ptr);
      in_ready  = !full;
      out_valid = !empty;
      push      = in_valid && !full;
      pop       = out_ready && !empty;
      out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
   end

   // Pointer update; reset flushes the contents
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write
   always_ff @(posedge ACLK) begin
      if (push) mem[wr_ptr[AW-1:0]] <= in_data;
   end

endmodule

// File: rtl/axis_pkt_rx.sv
// AXI-Stream packet receiver: buffers beats, checks per-packet sideband
// usage and emits one descriptor per packet at TLAST.
module axis_pkt_rx
   import axis_pkt_rx_pkg::*;
#(
   parameter  int unsigned DATA_W      = 32,
   parameter  int unsigned ID_W        = 4,   // at most ID_MAX_W
   parameter  int unsigned DEST_W      = 4,   // at most DEST_MAX_W
   parameter  int unsigned USER_W      = 1,
   parameter  int unsigned DEPTH       = 16,
   parameter  int unsigned DESC_DEPTH  = 4,
   localparam int unsigned KEEP_STRB_W = DATA_W / 8
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   input  logic                   TVALID,
   output logic                   TREADY,
   input  logic [DATA_W-1:0]      TDATA,
   input  logic [KEEP_STRB_W-1:0] TSTRB,
   input  logic [KEEP_STRB_W-1:0] TKEEP,
   input  logic                   TLAST,
   input  logic [ID_W-1:0]        TID,
   input  logic [DEST_W-1:0]      TDEST,
   input  logic [USER_W-1:0]      TUSER,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [DATA_W-1:0]      rd_data,
   output logic [KEEP_STRB_W-1:0] rd_keep,
   output logic [USER_W-1:0]      rd_user,
   output logic                   rd_last,
   output logic                   desc_valid,
   input  logic                   desc_ready,
   output logic [15:0]            desc_bytes,
   output logic [ID_W-1:0]        desc_id,
   output logic [DEST_W-1:0]      desc_dest,
   output logic                   desc_err
);

   localparam int unsigned BEAT_W = DATA_W + KEEP_STRB_W + USER_W + 1;

   state_t                  state_q, state_d;
   logic                    beat_in_ready, desc_in_ready;
   logic                    accept, first_beat, desc_push;
   logic [15:0]             bytes_q, bytes_nxt;
   logic [ID_W-1:0]         id_q, id_nxt;
   logic [DEST_W-1:0]       dest_q, dest_nxt;
   logic                    err_q, err_nxt;
   logic [16:0]             sum;
   logic                    sat, beat_err, hdr_err;
   logic [KEEP_MAX_W-1:0]   keep_ext;
   logic [BEAT_W-1:0]       beat_out;
   desc_t                   desc_in, desc_out;
   logic                    desc_unused;

   // FSM state register
   always_ff @(posedge ACLK) begin
      if (ARESET) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: any accepted beat opens a packet, TLAST closes it
   always_comb begin
      state_d = state_q;
      if (accept) state_d = TLAST ? S_IDLE : S_IN_PKT;
   end

   // FSM outputs: intake handshake and descriptor push
   always_comb begin
      TREADY     = !ARESET && beat_in_ready && desc_in_ready;
      accept     = TVALID && TREADY;
      first_beat = (state_q == S_IDLE);
      desc_push  = accept && TLAST;
   end

   // Per-beat checks and the packet totals including the current beat
   always_comb begin
      keep_ext  = KEEP_MAX_W'(TKEEP);
      beat_err  = !keep_contiguous(keep_ext) || (TKEEP == '0) || ((TSTRB & ~TKEEP) != '0);
      hdr_err   = !first_beat && ((TID != id_q) || (TDEST != dest_q));
      sum       = (first_beat ? 17'd0 : {1'b0, bytes_q}) + 17'(popcount(keep_ext));
      sat       = sum > {1'b0, BYTE_SAT};
      bytes_nxt = sat ? BYTE_SAT : sum[15:0];
      id_nxt    = first_beat ? TID : id_q;
      dest_nxt  = first_beat ? TDEST : dest_q;
      err_nxt   = (!first_beat && err_q) || beat_err || hdr_err || sat;
      desc_in.bytes = bytes_nxt;
      desc_in.id    = ID_MAX_W'(id_nxt);
      desc_in.dest  = DEST_MAX_W'(dest_nxt);
      desc_in.err   = err_nxt;
   end

   // Packet accumulator, updated on every accepted beat
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         bytes_q <= '0;
         id_q    <= '0;
         dest_q  <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         bytes_q <= bytes_nxt;
         id_q    <= id_nxt;
         dest_q  <= dest_nxt;
         err_q   <= err_nxt;
      end
   end

   axis_sync_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (DEPTH)
   ) u_beat_fifo (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .in_valid  (accept),
      .in_ready  (beat_in_ready),
      .in_data   ({TDATA, TKEEP, TUSER, TLAST}),
      .out_valid (rd_valid),
      .out_ready (rd_ready),
      .out_data  (beat_out)
   );

   axis_sync_fifo #(
      .WIDTH ($bits(desc_t)),
      .DEPTH (DESC_DEPTH)
   ) u_desc_fifo (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .in_valid  (desc_push),
      .in_ready  (desc_in_ready),
      .in_data   (desc_in),
      .out_valid (desc_valid),
      .out_ready (desc_ready),
      .out_data  (desc_out)
   );

   assign {rd_data, rd_keep, rd_user, rd_last} = beat_out;

   assign desc_bytes = desc_out.bytes;
   assign desc_id    = desc_out.id[ID_W-1:0];
   assign desc_dest  = desc_out.dest[DEST_W-1:0];
   assign desc_err   = desc_out.err;
   // Upper id/dest bits are always zero here
   assign desc_unused = ^desc_out;

endmodule

// File: doc/axis_pkt_rx.md
# axis_pkt_rx

AXI-Stream slave-side packet receiver: the RTL sink that terminates a stream driven by the master agent. It accepts beats on an AXI-Stream slave port, buffers them in a beat FIFO, and validates each packet's TKEEP/TSTRB/TID/TDEST usage. At each TLAST it emits a per-packet descriptor with byte count, ID, destination and error flag. It is the DUT-side counterpart for the VIP master agent and the standard stream endpoint for downstream register/DMA logic.

## Interface
Parameters:
- DATA_W, 32, TDATA width in bits; must be a multiple of 8
- ID_W, 4, TID width
- DEST_W, 4, TDEST width
- USER_W, 1, TUSER width; stored alongside data
- DEPTH, 16, beat FIFO depth; power of 2, ≥ 2
- DESC_DEPTH, 4, descriptor FIFO depth; power of 2, ≥ 2
- KEEP_STRB_W, DATA_W/8, derived; not overridable

Ports:
- ACLK  in  1  single clock; all logic on posedge
- ARESET  in  1  synchronous reset, active-high
- TVALID, TREADY  in/out  1  slave handshake
- TDATA  in  DATA_W
- TSTRB, TKEEP  in  KEEP_STRB_W
- TLAST  in  1
- TID  in  ID_W
- TDEST  in  DEST_W
- TUSER  in  USER_W
- rd_valid / rd_ready  out/in  1  beat read handshake
- rd_data  out  DATA_W
- rd_keep  out  KEEP_STRB_W
- rd_user  out  USER_W
- rd_last  out  1
- desc_valid / desc_ready  out/in  1  descriptor handshake
- desc_bytes  out  16  byte count of the packet, saturating
- desc_id  out  ID_W  TID of the first beat
- desc_dest  out  DEST_W  TDEST of the first beat
- desc_err  out  1  protocol violation seen in the packet

## Operation
- Beat accepted when TVALID && TREADY. Store {TDATA, TKEEP, TUSER, TLAST} in the beat FIFO.
- TREADY = !ARESET && !beat_full && !desc_full. No pass-through: when full, TREADY stays 0 even if a pop occurs in the same cycle.
- Two-state FSM: IDLE, IN_PKT.
  - Accepted beat in IDLE latches TID/TDEST into the descriptor fields and clears the byte accumulator and error flag.
  - That beat moves the FSM to IN_PKT unless TLAST is also set.
  - Accepted beat with TLAST pushes the descriptor and returns the FSM to IDLE.
- Byte count: add popcount(TKEEP) per beat into a 17-bit accumulator. Clamp to 16'hFFFF and set err if the sum exceeds 65535.
- Error conditions (sticky for the packet):
  - TKEEP is not a contiguous low-order run of ones.
  - TKEEP == 0.
  - (TSTRB & ~TKEEP) != 0.
  - TID or TDEST differs from the first-beat values while in IN_PKT.
- Errored packets are still fully stored and forwarded; only desc_err marks them.
- Beat-read and descriptor ports are independent. Data may drain before the descriptor appears.

## Timing
- Reset values:
  - TREADY = 0 while ARESET is high, 1 on the first cycle after release.
  - rd_valid = 0, desc_valid = 0, both FIFOs empty, FSM = IDLE.
  - All data outputs are 0.
- Beat accepted at edge N → rd_valid high from N+1; rd_* stable while rd_valid && !rd_ready.
- TLAST accepted at edge N → desc_valid high from N+1.
- Full throughput: one beat per cycle in, one per cycle out, with simultaneous push/pop while not full.
- Reset mid-packet: the partial packet is discarded, both FIFOs are flushed, and no descriptor is emitted for it.
- Pointer wrap: log2(DEPTH)+1-bit pointers; full when the MSBs differ and the lower bits are equal.

## Structure
- Package axis_pkt_rx_pkg holds:
  - desc_t packed struct {bytes, id, dest, err}.
  - Function keep_contiguous().
  - Function popcount().
  - Localparam for the byte-count saturation value.
- Sub-module axis_sync_fifo (parameterised WIDTH, DEPTH; valid/ready on both sides). Instantiated twice: beat FIFO and descriptor FIFO.

## Test plan
- Single packet: 3 beats, TKEEP F,F,3, TID 2, TDEST 5, TSTRB = TKEEP → desc {bytes 10, id 2, dest 5, err 0}; rd_last on the third beat.
- Backpressure: 20 beats, rd_ready = 0 → TREADY drops after 16 accepted. Releasing rd_ready resumes intake, with no beat lost or duplicated.
- TKEEP 4'b0101 on the last beat → desc_err = 1, bytes includes 2 from that beat. The data is still delivered.
- TID changes 2→3 on beat 2 → desc_id = 2, desc_err = 1.
- Descriptor FIFO full: 4 one-beat packets with desc_ready = 0 → TREADY = 0 on the 5th. One descriptor pop restores TREADY the next cycle.
- ARESET asserted after 2 beats of a 4-beat packet → TREADY = 0, rd_valid = 0, desc_valid = 0 next cycle. The next packet after release reports its own bytes only.
